dma_controller: RTL and testbench
=================================

Name: dma_controller

Overview:
- Single-channel, word-granular DMA engine. Copies transfer_size 32-bit words from a source address to a destination address over a shared memory bus.
- Handshakes with a requester (dma_request/dma_ack) and a bus arbiter (bus_request/bus_grant).
- Sits between the system arbiter and the memory port; each word is one read beat followed by one write beat.

Parameters:
- ADDR_W, 32, address width of src/dest/addr_out.
- DATA_W, 32, data word width.
- CNT_W, 16, width of transfer_size and the word counter.
- ADDR_STEP, 4, byte increment per word.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- dma_request  in  1  requester wants a transfer
- dma_ack  out  1  high while the controller owns the bus for the request
- bus_request  out  1  request bus from arbiter
- bus_grant  in  1  arbiter grant
- src_addr  in  32  source byte address, latched at start
- dest_addr  in  32  destination byte address, latched at start
- transfer_size  in  16  word count, latched at start
- start_transfer  in  1  start qualifier
- transfer_done  out  1  one-cycle completion pulse
- addr_out  out  32  memory address
- data_out  out  32  write data
- data_in  in  32  read data
- mem_read  out  1  read strobe
- mem_write  out  1  write strobe
- mem_ready  in  1  beat-complete handshake

Behaviour:
- All outputs are registered. On reset, every output is 0, the FSM is in IDLE, and the internal address/count/data registers are 0.
- States: IDLE, BUS_REQ, READ, WRITE, DONE.
- IDLE: when dma_request && start_transfer are sampled high, latch src_addr, dest_addr and transfer_size into internal registers.
  - Count != 0: go to BUS_REQ.
  - Count == 0: go directly to DONE with no bus or memory activity.
- BUS_REQ: bus_request = 1. When bus_grant is sampled high, assert dma_ack and go to READ.
- READ: mem_read = 1, addr_out = current src.
  - Hold until mem_ready is sampled high with mem_read high.
  - On that edge, capture data_in into the data register, drop mem_read, and go to WRITE.
- WRITE: mem_write = 1, addr_out = current dest, data_out = captured word.
  - Hold until mem_ready is sampled high with mem_write high.
  - On that edge: src += 4, dest += 4, count -= 1, and drop mem_write.
  - If the new count is 0, go to DONE.
  - Otherwise, if bus_grant is high go to READ; if bus_grant is low go to BUS_REQ, with dma_ack low until it is re-granted.
- DONE: transfer_done = 1 for exactly one cycle. bus_request, dma_ack, mem_read and mem_write are all 0. Return to IDLE.
- A new transfer requires dma_request && start_transfer to be sampled in IDLE. If both remain held high, a new transfer starts on the cycle after DONE.
- mem_read and mem_write are never high in the same cycle.
- bus_request stays high from BUS_REQ through the final WRITE beat.
- addr_out:
  - holds its last value in IDLE and DONE;
  - wraps modulo 2^32 on increment;
  - is not required to be aligned (low 2 bits are passed through).
- data_out holds its value outside WRITE.
- Inputs are ignored outside their states: bus_grant outside BUS_REQ/WRITE-completion, and mem_ready outside READ/WRITE.
- reset asserted mid-transfer: everything returns to reset values immediately. No transfer_done pulse, and the partial transfer is abandoned.
- Changes to src_addr, dest_addr or transfer_size during a transfer have no effect.

Decomposition:
- Package dma_pkg holds:
  - the state enum (IDLE, BUS_REQ, READ, WRITE, DONE);
  - ADDR_STEP;
  - the default widths.
- Single module, no sub-modules. The FSM and datapath registers (src, dest, count, data) are small enough to live together.

Test Plan:
- Basic copy: src=0x10, dest=0x100, size=4; source words 0xAAAA1111, 0xBBBB2222, 0xCCCC3333, 0xDDDD4444 at 0x10–0x1C; grant 3 cycles after request; memory asserts mem_ready one cycle after each strobe.
  - Required: four writes to 0x100, 0x104, 0x108, 0x10C with those data in order.
  - Required: exactly one transfer_done pulse, then bus_request = 0.
- Grant latency: hold bus_grant low for 10 cycles.
  - Required: bus_request = 1, dma_ack = 0, and no mem_read/mem_write until the grant arrives.
  - Required: first mem_read occurs the cycle after the grant is sampled.
- Zero size: transfer_size=0.
  - Required: no bus_request and no memory strobes.
  - Required: transfer_done pulses one cycle after start is sampled.
- mem_ready stall: delay mem_ready 5 cycles on the second read.
  - Required: mem_read and addr_out=0x14 are held steady across the stall.
  - Required: the data written to 0x104 is 0xBBBB2222.
- Grant drop: deassert bus_grant after the first write completes.
  - Required: return to BUS_REQ with dma_ack = 0.
  - Required: after re-grant, the transfer resumes at src 0x14 / dest 0x104 and completes all 4 words.
- Reset mid-transfer: assert reset during the second WRITE.
  - Required: all outputs are 0 immediately, with no transfer_done.
  - Required: a new start afterwards copies from the newly latched addresses.

Source files
------------

// File: rtl/dma_pkg.sv
// ---------------------------------------------------------------------------
// dma_pkg
// Shared definitions for the single-channel DMA engine:
//   - default address / data / counter widths
//   - byte increment applied to src and dest after every word
//   - the controller state encoding
// ---------------------------------------------------------------------------
package dma_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;

  // One 32-bit word per beat, so both pointers move by four bytes.
  localparam int ADDR_STEP  = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BUS_REQ = 3'd1,
    ST_READ    = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DONE    = 3'd4
  } dma_state_t;

endpackage : dma_pkg

// File: rtl/dma_controller.sv
// ---------------------------------------------------------------------------
// dma_controller
// Single-channel, word-granular DMA engine. Copies transfer_size words from
// src_addr to dest_addr, one read beat followed by one write beat per word,
// after winning the shared bus from the system arbiter.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   dma_request       requester wants a transfer
//   start_transfer    qualifies dma_request; both sampled in IDLE
//   src_addr          source byte address, latched at start
//   dest_addr         destination byte address, latched at start
//   transfer_size     word count, latched at start (0 = no bus activity)
//   dma_ack           high while the controller holds a grant for the request
//   bus_request       bus request to the arbiter
//   bus_grant         arbiter grant
//   transfer_done     one-cycle completion pulse
//   addr_out          memory address (src in READ, dest in WRITE)
//   data_out          write data (word captured during the preceding READ)
//   data_in           read data, captured when a read beat completes
//   mem_read          read strobe
//   mem_write         write strobe
//   mem_ready         beat-complete handshake
// Every output comes straight from a register.
// ---------------------------------------------------------------------------
module dma_controller #(
  parameter int ADDR_W    = dma_pkg::ADDR_W_DEF,
  parameter int DATA_W    = dma_pkg::DATA_W_DEF,
  parameter int CNT_W     = dma_pkg::CNT_W_DEF,
  parameter int ADDR_STEP = dma_pkg::ADDR_STEP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dma_request,
  output logic              dma_ack,
  output logic              bus_request,
  input  logic              bus_grant,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic [CNT_W-1:0]  transfer_size,
  input  logic              start_transfer,
  output logic              transfer_done,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] data_out,
  input  logic [DATA_W-1:0] data_in,
  output logic              mem_read,
  output logic              mem_write,
  input  logic              mem_ready
);

  import dma_pkg::*;

  dma_state_t        r_state;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dest;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W-1:0] r_addrOut;
  logic              r_dmaAck;
  logic              r_busRequest;
  logic              r_transferDone;
  logic              r_memRead;
  logic              r_memWrite;

  dma_state_t        w_nextState;
  logic [ADDR_W-1:0] w_nextSrc;
  logic [ADDR_W-1:0] w_nextDest;
  logic [CNT_W-1:0]  w_nextCount;
  logic [DATA_W-1:0] w_nextData;
  logic [ADDR_W-1:0] w_nextAddrOut;
  logic              w_nextDmaAck;
  logic              w_nextBusRequest;
  logic              w_nextTransferDone;
  logic              w_nextMemRead;
  logic              w_nextMemWrite;

  logic [ADDR_W-1:0] w_srcInc;
  logic [ADDR_W-1:0] w_destInc;
  logic              w_start;
  logic              w_lastWord;

  // Pointer increments wrap naturally at the address width; low bits are
  // carried through untouched so unaligned pointers stay unaligned.
  assign w_srcInc   = r_src  + ADDR_W'(ADDR_STEP);
  assign w_destInc  = r_dest + ADDR_W'(ADDR_STEP);
  assign w_start    = dma_request && start_transfer;
  assign w_lastWord = (r_count == CNT_W'(1));

  // Outputs are driven directly from their registers.
  assign dma_ack       = r_dmaAck;
  assign bus_request   = r_busRequest;
  assign transfer_done = r_transferDone;
  assign addr_out      = r_addrOut;
  assign data_out      = r_data;
  assign mem_read      = r_memRead;
  assign mem_write     = r_memWrite;

  // State and datapath register bank. Reset clears every register, which
  // also abandons any partial transfer without a completion pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_src          <= '0;
      r_dest         <= '0;
      r_count        <= '0;
      r_data         <= '0;
      r_addrOut      <= '0;
      r_dmaAck       <= 1'b0;
      r_busRequest   <= 1'b0;
      r_transferDone <= 1'b0;
      r_memRead      <= 1'b0;
      r_memWrite     <= 1'b0;
    end else begin
      r_state        <= w_nextState;
      r_src          <= w_nextSrc;
      r_dest         <= w_nextDest;
      r_count        <= w_nextCount;
      r_data         <= w_nextData;
      r_addrOut      <= w_nextAddrOut;
      r_dmaAck       <= w_nextDmaAck;
      r_busRequest   <= w_nextBusRequest;
      r_transferDone <= w_nextTransferDone;
      r_memRead      <= w_nextMemRead;
      r_memWrite     <= w_nextMemWrite;
    end
  end

  // Next-state and next-output logic. Because outputs are registered, each
  // transition also sets up the output values of the state being entered:
  // e.g. the grant edge raises mem_read so the read beat starts the very
  // next cycle. Everything holds by default; the done pulse clears itself.
  always_comb begin
    w_nextState        = r_state;
    w_nextSrc          = r_src;
    w_nextDest         = r_dest;
    w_nextCount        = r_count;
    w_nextData         = r_data;
    w_nextAddrOut      = r_addrOut;
    w_nextDmaAck       = r_dmaAck;
    w_nextBusRequest   = r_busRequest;
    w_nextTransferDone = 1'b0;
    w_nextMemRead      = r_memRead;
    w_nextMemWrite     = r_memWrite;

    unique case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_nextSrc   = src_addr;
          w_nextDest  = dest_addr;
          w_nextCount = transfer_size;
          if (transfer_size != '0) begin
            w_nextState      = ST_BUS_REQ;
            w_nextBusRequest = 1'b1;
          end else begin
            // Empty transfer: report completion without touching the bus.
            w_nextState        = ST_DONE;
            w_nextTransferDone = 1'b1;
          end
        end
      end

      ST_BUS_REQ: begin
        w_nextBusRequest = 1'b1;
        if (bus_grant) begin
          w_nextState   = ST_READ;
          w_nextDmaAck  = 1'b1;
          w_nextMemRead = 1'b1;
          w_nextAddrOut = r_src;
        end
      end

      ST_READ: begin
        if (mem_ready && r_memRead) begin
          w_nextState    = ST_WRITE;
          w_nextData     = data_in;
          w_nextMemRead  = 1'b0;
          w_nextMemWrite = 1'b1;
          w_nextAddrOut  = r_dest;
        end
      end

      ST_WRITE: begin
        if (mem_ready && r_memWrite) begin
          w_nextMemWrite = 1'b0;
          w_nextSrc      = w_srcInc;
          w_nextDest     = w_destInc;
          w_nextCount    = r_count - CNT_W'(1);
          if (w_lastWord) begin
            w_nextState        = ST_DONE;
            w_nextTransferDone = 1'b1;
            w_nextBusRequest   = 1'b0;
            w_nextDmaAck       = 1'b0;
          end else if (bus_grant) begin
            // Still granted: go straight into the next read beat.
            w_nextState   = ST_READ;
            w_nextMemRead = 1'b1;
            w_nextAddrOut = w_srcInc;
          end else begin
            // Grant withdrawn between words: keep requesting, drop ack.
            w_nextState  = ST_BUS_REQ;
            w_nextDmaAck = 1'b0;
          end
        end
      end

      ST_DONE: begin
        w_nextState      = ST_IDLE;
        w_nextBusRequest = 1'b0;
        w_nextDmaAck     = 1'b0;
        w_nextMemRead    = 1'b0;
        w_nextMemWrite   = 1'b0;
      end

      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

endmodule : dma_controller

// File: tb/tb_dma_controller.sv
// ---------------------------------------------------------------------------
// tb_dma_controller
// Self-checking bench for dma_controller. A behavioural memory answers the
// read/write strobes, an arbiter model hands out (and sometimes withdraws)
// the bus grant, and every completed write beat is logged. Expected writes
// come from a plain model: word i goes to dest+4*i carrying the memory word
// at src+4*i.
// ---------------------------------------------------------------------------
module tb_dma_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dma_request = 1'b0;
  logic        dma_ack;
  logic        bus_request;
  logic        bus_grant;
  logic [31:0] src_addr = '0;
  logic [31:0] dest_addr = '0;
  logic [15:0] transfer_size = '0;
  logic        start_transfer = 1'b0;
  logic        transfer_done;
  logic [31:0] addr_out;
  logic [31:0] data_out;
  logic [31:0] data_in = '0;
  logic        mem_read;
  logic        mem_write;
  logic        mem_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  // Memory contents and observed traffic
  logic [31:0] mem [logic [31:0]];
  logic [63:0] wrLog [$];
  int          readNum = 0;
  int          stallReadAbs = 0;
  int          stallCycles = 0;
  bit          randLat = 1'b0;

  // Arbiter controls
  bit          grantMode = 1'b1;
  bit          manualGrant = 1'b0;
  logic        autoGrant = 1'b0;
  int          grantDelay = 1;
  bit          dropEnable = 1'b0;

  // Monitor counters (monotonic, only the monitor writes them)
  int doneCnt = 0;
  int busCycles = 0;
  int overlapCnt = 0;
  int wideDone = 0;

  assign bus_grant = grantMode ? autoGrant : manualGrant;

  dma_controller dut (
    .clk            (clk),
    .reset          (reset),
    .dma_request    (dma_request),
    .dma_ack        (dma_ack),
    .bus_request    (bus_request),
    .bus_grant      (bus_grant),
    .src_addr       (src_addr),
    .dest_addr      (dest_addr),
    .transfer_size  (transfer_size),
    .start_transfer (start_transfer),
    .transfer_done  (transfer_done),
    .addr_out       (addr_out),
    .data_out       (data_out),
    .data_in        (data_in),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_ready      (mem_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memRead(logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  // Memory responder: answers each strobe after a latency (normally one
  // cycle), and logs a write once the DUT has sampled mem_ready with it.
  int          age = 0;
  int          curLat = 1;
  bit          lastWr = 1'b0;
  logic [31:0] lastAddr = '0;
  logic [31:0] lastData = '0;
  always @(posedge clk) begin
    #1;
    if (reset) begin
      mem_ready = 1'b0;
      age = 0;
    end else begin
      if (mem_ready) begin
        if (lastWr) wrLog.push_back({lastAddr, lastData});
        mem_ready = 1'b0;
        age = 0;
      end
      if (mem_read || mem_write) begin
        if (age == 0) begin
          if (mem_read) readNum++;
          if (mem_read && readNum == stallReadAbs) curLat = 1 + stallCycles;
          else curLat = randLat ? int'($urandom_range(1, 3)) : 1;
        end
        if (age >= curLat) begin
          mem_ready = 1'b1;
          if (mem_read) data_in = memRead(addr_out);
        end else begin
          age++;
        end
      end
    end
    lastWr   = mem_write;
    lastAddr = addr_out;
    lastData = data_out;
  end

  // Automatic arbiter: grants grantDelay cycles after a request, and may
  // withdraw the grant during a write beat when dropEnable is set.
  int gcnt = 0;
  always @(posedge clk) begin
    #1;
    if (reset || !bus_request) begin
      autoGrant = 1'b0;
      gcnt = 0;
    end else if (!autoGrant) begin
      if (gcnt >= grantDelay) begin
        autoGrant = 1'b1;
        gcnt = 0;
      end else begin
        gcnt++;
      end
    end else if (dropEnable && mem_write && $urandom_range(0, 3) == 0) begin
      autoGrant = 1'b0;
      grantDelay = $urandom_range(0, 4);
    end
  end

  // Protocol monitor
  bit prevDone = 1'b0;
  always @(posedge clk) begin
    #1;
    if (transfer_done) doneCnt++;
    if (transfer_done && prevDone) wideDone++;
    if (bus_request) busCycles++;
    if (mem_read && mem_write) overlapCnt++;
    prevDone = transfer_done;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a start for one sampling edge, then scramble the address/size
  // inputs so any late use of them would corrupt the transfer.
  task automatic applyStimulus(input logic [31:0] src, input logic [31:0] dest,
                               input logic [15:0] size);
    src_addr       = src;
    dest_addr      = dest;
    transfer_size  = size;
    dma_request    = 1'b1;
    start_transfer = 1'b1;
    waitCycles(1);
    dma_request    = 1'b0;
    start_transfer = 1'b0;
    src_addr       = $urandom;
    dest_addr      = $urandom;
    transfer_size  = 16'($urandom);
  endtask

  task automatic waitDone(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      if (transfer_done) seen = 1'b1;
      else waitCycles(1);
    end
    checkOutput({name, " done seen"}, 32'(seen), 32'd1);
  endtask

  // Reference model comparison for the writes logged from index base on.
  task automatic checkTransfer(input string name, input logic [31:0] src,
                               input logic [31:0] dest, input int size, input int base);
    logic [31:0] expAddr;
    logic [31:0] expData;
    checkOutput({name, " write count"}, 32'(wrLog.size() - base), 32'(size));
    for (int i = 0; i < size; i++) begin
      expAddr = dest + 32'(4 * i);
      expData = memRead(src + 32'(4 * i));
      if (base + i < wrLog.size()) begin
        checkOutput($sformatf("%s write%0d addr", name, i), wrLog[base + i][63:32], expAddr);
        checkOutput($sformatf("%s write%0d data", name, i), wrLog[base + i][31:0], expData);
      end
    end
  endtask

  task automatic runOne(input string name, input logic [31:0] src, input logic [31:0] dest,
                        input logic [15:0] size, input int expWrites,
                        input logic [31:0] expLast, input bit expBus);
    int d0 = doneCnt;
    int b0 = busCycles;
    int o0 = overlapCnt;
    int w0 = wideDone;
    int base = wrLog.size();
    applyStimulus(src, dest, size);
    waitDone(name);
    waitCycles(2);
    checkOutput({name, " done pulses"}, 32'(doneCnt - d0), 32'd1);
    checkOutput({name, " done width"}, 32'(wideDone - w0), 32'd0);
    checkOutput({name, " bus used"}, 32'(busCycles != b0), 32'(expBus));
    checkOutput({name, " rd/wr overlap"}, 32'(overlapCnt - o0), 32'd0);
    checkOutput({name, " idle outputs"},
                {28'd0, bus_request, dma_ack, mem_read, mem_write}, 32'd0);
    if (expWrites > 0 && wrLog.size() >= base + expWrites)
      checkOutput({name, " last addr"}, wrLog[base + expWrites - 1][63:32], expLast);
    checkTransfer(name, src, dest, int'(size), base);
  endtask

  typedef struct {
    logic [31:0] src;
    logic [31:0] dest;
    logic [15:0] size;
    int          gDelay;
    int          expWrites;
    logic [31:0] expLast;
    bit          expBus;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int base;
    int hold;
    int d0;
    bit found;
    logic [31:0] rs;
    logic [31:0] rd;
    logic [15:0] rz;

    vecs[0] = '{32'h0000_0010, 32'h0000_0100, 16'd4, 3, 4, 32'h0000_010C, 1'b1};
    vecs[1] = '{32'h0000_0020, 32'h0000_0200, 16'd0, 0, 0, 32'h0000_0000, 1'b0};
    vecs[2] = '{32'hFFFF_FFF8, 32'h0000_9000, 16'd4, 1, 4, 32'h0000_900C, 1'b1};
    vecs[3] = '{32'h0000_0013, 32'hFFFF_FFFC, 16'd2, 0, 2, 32'h0000_0000, 1'b1};
    vecs[4] = '{32'h0000_0040, 32'h0000_0300, 16'd1, 5, 1, 32'h0000_0300, 1'b1};

    mem[32'h10] = 32'hAAAA_1111;
    mem[32'h14] = 32'hBBBB_2222;
    mem[32'h18] = 32'hCCCC_3333;
    mem[32'h1C] = 32'hDDDD_4444;
    mem[32'h30] = 32'h1234_5678;
    mem[32'h34] = 32'h9ABC_DEF0;

    // Reset state
    waitCycles(3);
    checkOutput("reset ctrl",
                {27'd0, dma_ack, bus_request, transfer_done, mem_read, mem_write}, 32'd0);
    checkOutput("reset addr_out", addr_out, 32'd0);
    checkOutput("reset data_out", data_out, 32'd0);
    reset = 1'b0;
    waitCycles(2);

    // Table vectors (row 0 is the basic four-word copy)
    foreach (vecs[i]) begin
      grantDelay = vecs[i].gDelay;
      runOne($sformatf("vec%0d", i), vecs[i].src, vecs[i].dest, vecs[i].size,
             vecs[i].expWrites, vecs[i].expLast, vecs[i].expBus);
    end

    // Zero size: done visible right after the sampling edge, no bus request
    applyStimulus(32'h50, 32'h500, 16'd0);
    checkOutput("zero done timing", 32'(transfer_done), 32'd1);
    checkOutput("zero no bus_request", 32'(bus_request), 32'd0);
    waitCycles(2);

    // Held request: a new empty transfer restarts right after DONE
    src_addr = 32'h60; dest_addr = 32'h600; transfer_size = 16'd0;
    dma_request = 1'b1; start_transfer = 1'b1;
    waitCycles(1);
    checkOutput("held done #1", 32'(transfer_done), 32'd1);
    waitCycles(1);
    checkOutput("held idle gap", 32'(transfer_done), 32'd0);
    waitCycles(1);
    checkOutput("held done #2", 32'(transfer_done), 32'd1);
    dma_request = 1'b0; start_transfer = 1'b0;
    waitCycles(3);

    // Grant latency: ten cycles requesting with no ack and no strobes
    grantMode = 1'b0; manualGrant = 1'b0;
    base = wrLog.size();
    applyStimulus(32'h10, 32'h100, 16'd2);
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("grant wait c%0d", i),
                  {28'd0, bus_request, dma_ack, mem_read, mem_write}, 32'b1000);
      waitCycles(1);
    end
    manualGrant = 1'b1;
    waitCycles(1);
    checkOutput("grant first read", {30'd0, mem_read, dma_ack}, 32'b11);
    checkOutput("grant first addr", addr_out, 32'h10);
    waitDone("grant");
    waitCycles(2);
    checkTransfer("grant", 32'h10, 32'h100, 2, base);

    // Grant drop between words
    base = wrLog.size();
    manualGrant = 1'b1;
    applyStimulus(32'h10, 32'h100, 16'd4);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (mem_write) found = 1'b1;
      else waitCycles(1);
    end
    manualGrant = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (!mem_write) found = 1'b1;
      else waitCycles(1);
    end
    checkOutput("drop back to bus_req",
                {28'd0, bus_request, dma_ack, mem_read, mem_write}, 32'b1000);
    waitCycles(3);
    checkOutput("drop still waiting",
                {28'd0, bus_request, dma_ack, mem_read, mem_write}, 32'b1000);
    manualGrant = 1'b1;
    waitCycles(1);
    checkOutput("regrant read", {30'd0, mem_read, dma_ack}, 32'b11);
    checkOutput("regrant src", addr_out, 32'h14);
    waitDone("drop");
    waitCycles(2);
    checkTransfer("drop", 32'h10, 32'h100, 4, base);
    grantMode = 1'b1;

    // mem_ready stall on the second read
    grantDelay = 1;
    base = wrLog.size();
    stallReadAbs = readNum + 2;
    stallCycles = 5;
    applyStimulus(32'h10, 32'h100, 16'd4);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (mem_read && addr_out == 32'h14) found = 1'b1;
      else waitCycles(1);
    end
    hold = 0;
    while (mem_read && addr_out == 32'h14 && hold < 50) begin
      hold++;
      waitCycles(1);
    end
    checkOutput("stall read held cycles", 32'(hold), 32'd7);
    waitDone("stall");
    waitCycles(2);
    stallReadAbs = 0;
    stallCycles = 0;
    checkTransfer("stall", 32'h10, 32'h100, 4, base);

    // Reset during the second write beat
    base = wrLog.size();
    applyStimulus(32'h10, 32'h100, 16'd4);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (mem_write && wrLog.size() == base + 1) found = 1'b1;
      else waitCycles(1);
    end
    checkOutput("reached second write", 32'(found), 32'd1);
    d0 = doneCnt;
    reset = 1'b1;
    #1;
    checkOutput("midreset ctrl",
                {27'd0, dma_ack, bus_request, transfer_done, mem_read, mem_write}, 32'd0);
    checkOutput("midreset addr_out", addr_out, 32'd0);
    checkOutput("midreset data_out", data_out, 32'd0);
    waitCycles(2);
    reset = 1'b0;
    waitCycles(5);
    checkOutput("midreset no done", 32'(doneCnt - d0), 32'd0);
    runOne("after reset", 32'h30, 32'h400, 16'd2, 2, 32'h404, 1'b1);

    // Randomised transfers with random latency and grant withdrawals
    randLat = 1'b1;
    dropEnable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      rs = 32'h1000 + ($urandom & 32'hFFF);
      rd = 32'h8000 + ($urandom & 32'hFFF);
      rz = 16'($urandom_range(0, 6));
      grantDelay = $urandom_range(0, 4);
      runOne($sformatf("rand%0d", i), rs, rd, rz, int'(rz),
             rd + 32'(4 * (int'(rz) - 1)), rz != 16'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_dma_controller
